// File: rtl/alu_arb_pkg.sv
// ============================================================================
//  Module      : alu_arb_pkg
//  Description : Shared types and ALU operation codes for the ALU arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // ALU operation codes (passed through untouched by the arbiter)
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_BEQ  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_BNE  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_BLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_BGE  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_BLTU = 4'b1110;
    localparam logic [3:0] OP_BGEU = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches the request
//                vector upward from the pointer with wrap-around and returns
//                a one-hot grant, the winner index and an any-request flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // First set request at or after the pointer, modulo NUM_REQ
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter sharing one ALU between NUM_REQ
//                requesters. Registers op/operands to the ALU, captures the
//                combinational result and returns it over valid/ready.
//                Optional macro ALU_ARB_PERF_EN adds per-requester 16-bit
//                grant counters on o_grant_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*4-1:0]      i_req_op,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    input  logic [NUM_REQ-1:0]        i_rsp_ready,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic [3:0]                o_alu_op,
    output logic [DATA_W-1:0]         o_alu_a,
    output logic [DATA_W-1:0]         o_alu_b,
    input  logic [DATA_W-1:0]         i_alu_result
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]     o_grant_cnt
`endif
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [c_IDX_W-1:0]   r_owner;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [3:0]           r_alu_op;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;
    logic [DATA_W-1:0]    r_rsp_data;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_rsp_done;
    logic [c_IDX_W-1:0]   w_ptr_nxt;
    logic [3:0]           w_sel_op;
    logic [DATA_W-1:0]    w_sel_a;
    logic [DATA_W-1:0]    w_sel_b;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Payload mux for the current winner
    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_idx == c_IDX_W'(k)) begin
                w_sel_op = i_req_op[k*4 +: 4];
                w_sel_a  = i_req_a[k*DATA_W +: DATA_W];
                w_sel_b  = i_req_b[k*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves just past the owner once its response is consumed
    assign w_ptr_nxt = (r_owner == c_IDX_W'(NUM_REQ-1)) ? '0 : r_owner + c_IDX_W'(1);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        o_rsp_valid = '0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready = w_grant;
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                o_rsp_valid[r_owner] = 1'b1;
                if (i_rsp_ready[r_owner]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ALU operand registers, owner, result capture and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_owner  <= w_idx;
                r_alu_op <= w_sel_op;
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
            end
            if (w_capture) begin
                r_rsp_data <= i_alu_result;
            end
            if (w_rsp_done) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign o_alu_op   = r_alu_op;
    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_rsp_data = r_rsp_data;

`ifdef ALU_ARB_PERF_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf_cnt
        logic [15:0] r_cnt;
        // Count accepts for this requester, wrapping naturally at 16 bits
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_accept && (w_idx == c_IDX_W'(g))) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign o_grant_cnt[g*16 +: 16] = r_cnt;
    end
`else
    // Grant counters are not built in this configuration
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a transaction-level
//                reference model, directed scenarios and random traffic.
//                Grant counters are checked when ALU_ARB_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int N = 3;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid;
    logic [N-1:0]   rsp_ready;
    logic [3:0]     op [N];
    logic [W-1:0]   a  [N];
    logic [W-1:0]   b  [N];
    logic [N*4-1:0] req_op_v;
    logic [N*W-1:0] req_a_v;
    logic [N*W-1:0] req_b_v;

    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [3:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_result;
`ifdef ALU_ARB_PERF_EN
    logic [N*16-1:0] grant_cnt;
`endif

    always_comb begin
        req_op_v = '0;
        req_a_v  = '0;
        req_b_v  = '0;
        for (int i = 0; i < N; i++) begin
            req_op_v[i*4 +: 4] = op[i];
            req_a_v[i*W +: W]  = a[i];
            req_b_v[i*W +: W]  = b[i];
        end
    end

    function automatic logic [W-1:0] alu_f(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            OP_ADD:  alu_f = x + y;
            OP_SUB:  alu_f = x - y;
            OP_AND:  alu_f = x & y;
            OP_OR:   alu_f = x | y;
            OP_XOR:  alu_f = x ^ y;
            default: alu_f = x ^ ~y ^ {28'd0, o};
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    alu_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op_v),
        .i_req_a      (req_a_v),
        .i_req_b      (req_b_v),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_alu_op     (alu_op),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_result)
`ifdef ALU_ARB_PERF_EN
        ,
        .o_grant_cnt  (grant_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit           m_busy;
    int           m_ph;      // cycles since accept while busy
    int           m_owner;
    int           m_ptr;
    logic [3:0]   m_op;
    logic [W-1:0] m_a, m_b, m_data;
    int           m_gcnt [N];
    logic [N-1:0] tb_acc;

    function automatic int rr_exp(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_ph = 0; m_owner = 0; m_ptr = 0;
                m_op = '0; m_a = '0; m_b = '0; m_data = '0;
                for (int i = 0; i < N; i++) m_gcnt[i] = 0;
                tb_acc = '0;
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_alu_op", alu_op, 0);
                chk("rst_alu_a", alu_a, 0);
                chk("rst_alu_b", alu_b, 0);
            end else begin
                logic [N-1:0] er, ev;
                int w;
                er = '0; ev = '0; w = -1;
                if (!m_busy) begin
                    w = rr_exp(req_valid, m_ptr);
                    if (w >= 0) er[w] = 1'b1;
                end else if (m_ph >= 2) begin
                    ev[m_owner] = 1'b1;
                end
                chk("req_ready", req_ready, er);
                chk("rsp_valid", rsp_valid, ev);
                chk("rsp_data", rsp_data, m_data);
                chk("alu_op", alu_op, m_op);
                chk("alu_a", alu_a, m_a);
                chk("alu_b", alu_b, m_b);
`ifdef ALU_ARB_PERF_EN
                for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], m_gcnt[i]);
`endif
                tb_acc = req_ready & req_valid;
                if (!m_busy) begin
                    if (w >= 0) begin
                        m_busy = 1; m_ph = 1; m_owner = w;
                        m_op = op[w]; m_a = a[w]; m_b = b[w];
                        m_gcnt[w] = (m_gcnt[w] + 1) % 65536;
                    end
                end else if (m_ph == 1) begin
                    m_ph = 2;
                    m_data = alu_f(m_op, m_a, m_b);
                end else if (rsp_ready[m_owner]) begin
                    m_busy = 0;
                    m_ptr = (m_owner + 1) % N;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int ord [$];

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic new_payload(input int i);
        op[i] = 4'($urandom);
        a[i]  = $urandom;
        b[i]  = $urandom;
    endtask

    // Wait (bounded) until requester i is accepted; returns at that negedge
    task automatic wait_acc(input int i, input string nm);
        bit ok;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[i] && req_valid[i]) ok = 1;
        end
        if (!ok) chk(nm, 0, 1);
    endtask

    // Requesters in mask stay continuously valid for total grants; log order
    task automatic contention(input logic [N-1:0] mask, input int total);
        int acc;
        ord.delete();
        for (int i = 0; i < N; i++) new_payload(i);
        rsp_ready = '1;
        req_valid = mask;
        for (int c = 0; c < 40 * total && ord.size() < total; c++) begin
            @(negedge clk);
            acc = -1;
            for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) acc = i;
            @(posedge clk); #1;
            if (acc >= 0) begin
                ord.push_back(acc);
                new_payload(acc);
                if (ord.size() >= total) req_valid = '0;
            end
        end
        req_valid = '0;
        chk("order_count", ord.size(), total);
    endtask

    initial begin
        int nr;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin op[i] = '0; a[i] = '0; b[i] = '0; end

        // 1: single ADD, latency and literal result
        do_reset();
        op[0] = OP_ADD; a[0] = 5; b[0] = 7;
        rsp_ready = '1;
        req_valid = 3'b001;
        wait_acc(0, "t1_accept_timeout");
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("t1_exec_alu_op", alu_op, 4'b0010);
        chk("t1_exec_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 3'b001);
        chk("t1_rsp_data", rsp_data, 12);
        repeat (3) @(posedge clk);
        #1;

        // 2: two requesters, alternate 0,1,... from rr_ptr=0
        do_reset();
        contention(3'b011, 8);
        for (int k = 0; k < ord.size(); k++) chk("t2_order", ord[k], k % 2);
        repeat (3) @(posedge clk);
        #1;

        // 2b: all three contending rotate 0,1,2
        do_reset();
        contention(3'b111, 6);
        for (int k = 0; k < ord.size(); k++) chk("t2b_order", ord[k], k % 3);
        repeat (3) @(posedge clk);
        #1;

        // 3: back-pressure on owner 0, rsp_ready[1] high and ignored
        do_reset();
        new_payload(0); new_payload(1);
        rsp_ready = 3'b010;
        req_valid = 3'b001;
        wait_acc(0, "t3_accept_timeout");
        @(posedge clk); #1 req_valid = 3'b010;
        nr = 0;
        for (int c = 0; c < 10 && !rsp_valid[0]; c++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            chk("t3_hold_ready", req_ready, 0);
            chk("t3_hold_valid", rsp_valid, 3'b001);
            chk("t3_hold_data", rsp_data, alu_f(op[0], a[0], b[0]));
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 3'b011;
        @(negedge clk);
        chk("t3_handshake_valid", rsp_valid, 3'b001);
        @(negedge clk);
        chk("t3_req1_ready", req_ready, 3'b010);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // 4: reset during EXEC of SUB 9,4
        do_reset();
        op[0] = OP_SUB; a[0] = 9; b[0] = 4;
        rsp_ready = '1;
        req_valid = 3'b001;
        wait_acc(0, "t4_accept_timeout");
        @(posedge clk); #2 rst_n = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("t4_alu_a", alu_a, 0);
        chk("t4_alu_op", alu_op, 0);
        chk("t4_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t4_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        new_payload(1); new_payload(2);
        req_valid = 3'b110;
        @(negedge clk);
        chk("t4_ptr_zero_pick", req_ready, 3'b010);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // 5: random traffic obeying the hold-until-ready protocol
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && tb_acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    new_payload(i);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = N'($urandom);
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (6) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
